// File: rtl/animation_pkg.sv
// Shared definitions for the animation datapath: screen geometry, 3-bit colours,
// and the sweeper state encoding.
package animation_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    // Sums are kept wide so that positions past the screen edge are not aliased back on.
    function automatic logic on_screen(input logic [8:0] sum_x, input logic [7:0] sum_y);
        return (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/frame_sweeper_sweep_counter.sv
// Nested raster counter for one sprite rectangle: cx runs fastest, cy steps on cx wrap.
// Wraps to (0,0) after the last pixel so back-to-back passes need no idle cycle.
module sweep_counter
    import animation_pkg::*;
#(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] cx,
    output logic [3:0] cy,
    output logic       last
);

    localparam logic [3:0] CX_LAST = 4'(SPR_W - 1);
    localparam logic [3:0] CY_LAST = 4'(SPR_H - 1);

    logic [3:0] cx_q, cx_d;
    logic [3:0] cy_q, cy_d;
    logic       cx_wrap;

    always_comb begin
        cx_d    = cx_q;
        cy_d    = cy_q;
        cx_wrap = (cx_q == CX_LAST);
        if (clear) begin
            cx_d = 4'd0;
            cy_d = 4'd0;
        end else if (enable) begin
            if (cx_wrap) begin
                cx_d = 4'd0;
                cy_d = (cy_q == CY_LAST) ? 4'd0 : cy_q + 4'd1;
            end else begin
                cx_d = cx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cx_q <= 4'd0;
            cy_q <= 4'd0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

endmodule

// File: rtl/frame_sweeper.sv
// Frame-request responder: erases the sprite at its previous origin, redraws it at the
// new origin one pixel per clock into the VGA adapter port, then pulses done.
module frame_sweeper
    import animation_pkg::*;
#(
    parameter int         SPR_W     = 8,
    parameter int         SPR_H     = 8,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    sweep_state_e state_q, state_d;

    logic [7:0] new_x_q, new_x_d;
    logic [6:0] new_y_q, new_y_d;
    logic [2:0] new_colour_q, new_colour_d;
    logic [7:0] prev_x_q, prev_x_d;
    logic [6:0] prev_y_q, prev_y_d;
    logic       has_prev_q, has_prev_d;

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       cnt_clear;
    logic       cnt_enable;
    logic [3:0] cx;
    logic [3:0] cy;
    logic       cnt_last;

    logic [7:0] org_x;
    logic [6:0] org_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    sweep_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_sweep_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .cx      (cx),
        .cy      (cy),
        .last    (cnt_last)
    );

    // Pixel address for the current pass; the erase pass addresses the previous origin.
    always_comb begin
        org_x = (state_q == ST_ERASE) ? prev_x_q : new_x_q;
        org_y = (state_q == ST_ERASE) ? prev_y_q : new_y_q;
        sum_x = {1'b0, org_x} + {5'd0, cx};
        sum_y = {1'b0, org_y} + {4'd0, cy};
    end

    always_comb begin
        state_d      = state_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        new_colour_d = new_colour_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        has_prev_d   = has_prev_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (start) begin
                    new_x_d      = x_in;
                    new_y_d      = y_in;
                    new_colour_d = colour_in;
                    busy_d       = 1'b1;
                    state_d      = has_prev_q ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE: begin
                cnt_enable = 1'b1;
                x_d        = sum_x[7:0];
                y_d        = sum_y[6:0];
                colour_d   = BG_COLOUR;
                plot_d     = on_screen(sum_x, sum_y);
                if (cnt_last) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                cnt_enable = 1'b1;
                x_d        = sum_x[7:0];
                y_d        = sum_y[6:0];
                colour_d   = new_colour_q;
                plot_d     = on_screen(sum_x, sum_y);
                if (cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                prev_x_d   = new_x_q;
                prev_y_d   = new_y_q;
                has_prev_d = 1'b1;
                cnt_clear  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset also drops has_prev, so a sweep aborted by reset leaves no erase pending.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            new_x_q      <= 8'd0;
            new_y_q      <= 7'd0;
            new_colour_q <= 3'd0;
            prev_x_q     <= 8'd0;
            prev_y_q     <= 7'd0;
            has_prev_q   <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'd0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            new_colour_q <= new_colour_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            has_prev_q   <= has_prev_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_sweeper.sv
// Directed bench for frame_sweeper: a table of frame requests with hand-computed plot
// counts, plus sequences for ignored starts, mid-sweep reset and start held high.
module tb_frame_sweeper;
    import animation_pkg::*;

    localparam int PIX = 64;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int total;
    int bad;

    typedef struct {
        bit         do_reset;
        logic [7:0] nx;
        logic [6:0] ny;
        logic [2:0] nc;
        bit         erase;
        int         px;
        int         py;
        int         exp_plots;
    } frame_vec_t;

    frame_vec_t vecs[5];

    frame_sweeper #(
        .SPR_W     (8),
        .SPR_H     (8),
        .BG_COLOUR (3'b000)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .colour_in (colour_in),
        .busy      (busy),
        .done      (done),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] nc);
        @(negedge clock);
        x_in      = nx;
        y_in      = ny;
        colour_in = nc;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        start   = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Runs one frame and compares every sweep cycle against a raster model of the sprite.
    task automatic run_frame(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] nc,
                             input bit erase, input int px, input int py,
                             input int exp_plots, input bit inject);
        int len;
        int plots;
        int idx;
        int ox;
        int oy;
        int ex;
        int ey;
        logic [2:0] ec;
        len   = erase ? 2 * PIX : PIX;
        plots = 0;
        applyStimulus(nx, ny, nc);
        for (int k = 1; k <= len; k++) begin
            @(posedge clock);
            #1;
            idx = k - 1;
            if (erase && idx < PIX) begin
                ox = px;
                oy = py;
                ec = 3'b000;
            end else begin
                ox = int'(nx);
                oy = int'(ny);
                ec = nc;
                if (erase) idx = idx - PIX;
            end
            ex = ox + idx % 8;
            ey = oy + idx / 8;
            if (plot) plots++;
            if (ex < SCREEN_W && ey < SCREEN_H)
                checkOutput($sformatf("pixel k=%0d (%0d,%0d)", k, ex, ey),
                            int'({plot, x, y, colour, busy, done}),
                            int'({1'b1, ex[7:0], ey[6:0], ec, 1'b1, 1'b0}));
            else
                checkOutput($sformatf("clipped k=%0d (%0d,%0d)", k, ex, ey),
                            int'({plot, busy, done}), int'(3'b010));
            if (inject && (k == 5 || k == 40)) begin
                x_in  = 8'd90;
                y_in  = 7'd90;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("done pulse {plot,busy,done}", int'({plot, busy, done}), int'(3'b001));
        checkOutput("plot count", plots, exp_plots);
        @(posedge clock);
        #1;
        checkOutput("after done {plot,busy,done}", int'({plot, busy, done}), 0);
    endtask

    initial begin : main
        int plots;
        int n;
        int done_at[3];
        int frame_plots[3];

        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        x_in      = 8'd0;
        y_in      = 7'd0;
        colour_in = 3'd0;

        vecs[0] = '{1'b1, 8'd10,  7'd20,  3'b100, 1'b0, 0,   0,   64};
        vecs[1] = '{1'b0, 8'd11,  7'd20,  3'b010, 1'b1, 10,  20,  128};
        vecs[2] = '{1'b1, 8'd156, 7'd116, 3'b111, 1'b0, 0,   0,   16};
        vecs[3] = '{1'b0, 8'd150, 7'd115, 3'b001, 1'b1, 156, 116, 56};
        vecs[4] = '{1'b0, 8'd159, 7'd119, 3'b101, 1'b1, 150, 115, 41};

        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("reset plot",   int'(plot),   0);
        checkOutput("reset busy",   int'(busy),   0);
        checkOutput("reset done",   int'(done),   0);
        checkOutput("reset x",      int'(x),      0);
        checkOutput("reset y",      int'(y),      0);
        checkOutput("reset colour", int'(colour), 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_reset) do_reset();
            $display("[TB] frame vector %0d", i);
            run_frame(vecs[i].nx, vecs[i].ny, vecs[i].nc, vecs[i].erase,
                      vecs[i].px, vecs[i].py, vecs[i].exp_plots, 1'b0);
        end

        // Starts during a draw must be dropped; the following start erases the kept origin.
        do_reset();
        run_frame(8'd30, 7'd40, WHITE, 1'b0, 0, 0, 64, 1'b1);
        plots = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            if (plot || busy || done) plots++;
        end
        checkOutput("no queued frame", plots, 0);
        run_frame(8'd90, 7'd90, CYAN, 1'b1, 30, 40, 128, 1'b0);

        $display("[TB] reset during draw");
        applyStimulus(8'd60, 7'd60, RED);
        for (int k = 1; k <= 93; k++) begin
            @(posedge clock);
            #1;
        end
        checkOutput("draw pixel before reset", int'({plot, x, y, colour, busy}),
                    int'({1'b1, 8'd64, 7'd63, RED, 1'b1}));
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("abort {plot,busy,done}", int'({plot, busy, done}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_frame(8'd50, 7'd50, GREEN, 1'b0, 0, 0, 64, 1'b0);

        $display("[TB] start held high");
        do_reset();
        @(negedge clock);
        x_in      = 8'd0;
        y_in      = 7'd0;
        colour_in = WHITE;
        start     = 1'b1;
        plots     = 0;
        n         = 0;
        for (int i = 0; i < 3; i++) begin
            done_at[i]     = 0;
            frame_plots[i] = 0;
        end
        for (int c = 1; c <= 500 && n < 3; c++) begin
            @(posedge clock);
            #1;
            if (plot) begin
                plots++;
                checkOutput($sformatf("held pixel in 0..7 c=%0d", c), int'(x < 8 && y < 8), 1);
            end
            if (done) begin
                done_at[n]     = c;
                frame_plots[n] = plots;
                plots          = 0;
                n++;
            end
        end
        start = 1'b0;
        checkOutput("held done count", n, 3);
        checkOutput("held first done cycle", done_at[0], 66);
        checkOutput("held done gap 1", done_at[1] - done_at[0], 130);
        checkOutput("held done gap 2", done_at[2] - done_at[1], 130);
        checkOutput("held frame1 plots", frame_plots[0], 64);
        checkOutput("held frame2 plots", frame_plots[1], 128);
        checkOutput("held frame3 plots", frame_plots[2], 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
